// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: prescaled PWM sub-phases per digit slot,
// frame-synchronous shadow capture, per-digit blanking, DP and leading-zero suppression.
module seg_lane #(
  parameter int IDX = 0
) (
  input  logic [3:0] nib,
  input  logic       upper_zero,
  input  logic       lz,
  output logic [6:0] seg,
  output logic       suppress
);
  // Digit 0 is always shown so an all-zero value still reads "0".
  assign suppress = lz && (IDX != 0) && upper_zero && (nib == 4'h0);

  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              LEDout,
  output logic                    DP,
  output logic                    frame_tick
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]       pre;
  logic [BRIGHT_W-1:0] sub;
  logic [IW-1:0]       idx;
  logic                started;

  logic [NUM_DIGITS-1:0][3:0] sh_dig;
  logic [NUM_DIGITS-1:0]      sh_dp, sh_blank;
  logic                       sh_lz;

  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      lane_sup;
  logic [NUM_DIGITS:1]        zchain;   // zchain[i]: digits i..N-1 all zero

  logic sub_tick, sub_wrap, wrap, lit;

  assign sub_tick = (pre == PW'(REFRESH_DIV - 1));
  assign sub_wrap = sub_tick && (sub == '1);
  assign wrap     = started && sub_wrap && (idx == IW'(NUM_DIGITS - 1));

  assign zchain[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
      seg_lane #(.IDX(gi)) u_lane (
        .nib       (sh_dig[gi]),
        .upper_zero(zchain[gi+1]),
        .lz        (sh_lz),
        .seg       (lane_seg[gi]),
        .suppress  (lane_sup[gi])
      );
      if (gi > 0) begin : g_zc
        assign zchain[gi] = zchain[gi+1] && (sh_dig[gi] == 4'h0);
      end
    end
  endgenerate

  assign lit = (sub < brightness) && !sh_blank[idx] && !lane_sup[idx];

  // The first edge after reset only loads the shadows, so the first lit
  // cycle already shows the captured value instead of a stale zero.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      started  <= 1'b0;
      pre      <= '0;
      sub      <= '0;
      idx      <= '0;
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
    end else begin
      started <= 1'b1;
      if (!started || wrap) begin
        sh_dig   <= digits_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        sh_lz    <= lz_blank;
      end
      if (started) begin
        pre <= sub_tick ? '0 : pre + 1'b1;
        if (sub_tick) sub <= sub + 1'b1;
        if (sub_wrap) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Registered outputs: one anode at a time, switched in a single edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      AN         <= '1;
      LEDout     <= 7'h7F;
      DP         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (started && lit) begin
        AN     <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
        LEDout <= lane_seg[idx];
        DP     <= ~sh_dp[idx];
      end else begin
        AN     <= '1;
        LEDout <= 7'h7F;
        DP     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: position-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_seg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 2;
  localparam int BW = 2;
  localparam int SLOT  = RD * (1 << BW);
  localparam int FRAME = SLOT * ND;
  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic            clk_in = 1'b0;
  logic            rst;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0]   dp_in, blank_in;
  logic            lz_blank;
  logic [BW-1:0]   brightness;
  logic [ND-1:0]   AN;
  logic [6:0]      LEDout;
  logic            DP;
  logic            frame_tick;

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
    .clk_in(clk_in), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_blank(lz_blank), .brightness(brightness),
    .AN(AN), .LEDout(LEDout), .DP(DP), .frame_tick(frame_tick)
  );

  always #5 clk_in = ~clk_in;

  // ---- reference model: edge e after release shows scan position e-2 ----
  int            m_edges;
  logic [4*ND-1:0] m_dig;
  logic [ND-1:0] m_dp, m_blk;
  logic          m_lz;
  logic [ND-1:0] e_an;
  logic [6:0]    e_led;
  logic          e_dp, e_ft;

  function automatic logic [ND+7:0] model_out(int p, logic [4*ND-1:0] dig, logic [ND-1:0] dpv,
                                               logic [ND-1:0] blk, logic lz, logic [BW-1:0] br);
    int d, s;
    bit sup;
    logic [3:0] nib;
    d = (p / SLOT) % ND;
    s = (p / RD) % (1 << BW);
    sup = 1'b0;
    if (lz && d >= 1) begin
      sup = 1'b1;
      for (int k = d; k < ND; k++) if (dig[k*4 +: 4] != 4'h0) sup = 1'b0;
    end
    nib = dig[d*4 +: 4];
    if (s < int'(br) && !blk[d] && !sup) return {~(ND'(1) << d), DEC[nib], ~dpv[d]};
    return {{ND{1'b1}}, 7'h7F, 1'b1};
  endfunction

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_edges <= 0;
      m_dig <= '0; m_dp <= '0; m_blk <= '0; m_lz <= 1'b0;
      e_an <= '1; e_led <= 7'h7F; e_dp <= 1'b1; e_ft <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_edges % FRAME == 0) begin
        m_dig <= digits_in; m_dp <= dp_in; m_blk <= blank_in; m_lz <= lz_blank;
      end
      e_ft <= (m_edges > 0) && (m_edges % FRAME == 0);
      if (m_edges >= 1)
        {e_an, e_led, e_dp} <= model_out(m_edges - 1, m_dig, m_dp, m_blk, m_lz, brightness);
    end
  end

  // ---- checking ----
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int lowc [ND];
  logic [6:0] segv [ND];
  int dpl [ND];
  int offbad, ftpos;

  task automatic sample_frame(input int chg_at, input logic [4*ND-1:0] chg_val);
    for (int d = 0; d < ND; d++) begin lowc[d] = 0; segv[d] = 7'h7F; dpl[d] = 0; end
    offbad = 0; ftpos = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_in);
      if (i == chg_at) digits_in = chg_val;
      if (frame_tick) ftpos = i;
      for (int d = 0; d < ND; d++)
        if (AN == ~(ND'(1) << d)) begin
          lowc[d]++; segv[d] = LEDout;
          if (!DP) dpl[d]++;
        end
      if (AN == '1 && (LEDout != 7'h7F || DP != 1'b1)) offbad++;
    end
  endtask

  task automatic sync_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk_in);
      if (frame_tick) seen = 1'b1;
    end
    chk("sync_frame_tick_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b0; digits_in = 16'h1234; dp_in = '0; blank_in = '0;
    lz_blank = 1'b0; brightness = 2'd3;
    fork
      forever begin
        @(negedge clk_in);
        if (chk_en) begin
          chk("model_AN", 32'(AN), 32'(e_an));
          chk("model_LEDout", 32'(LEDout), 32'(e_led));
          chk("model_DP", 32'(DP), 32'(e_dp));
          chk("model_frame_tick", 32'(frame_tick), 32'(e_ft));
          chk("onehot_AN", 32'($countones(~AN) <= 1), 32'd1);
        end
      end
    join_none

    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    chk("reset_AN", 32'(AN), 32'hF);
    chk("reset_LEDout", 32'(LEDout), 32'h7F);
    chk("reset_DP", 32'(DP), 32'd1);
    chk("reset_frame_tick", 32'(frame_tick), 32'd0);

    // scan of 1234 at brightness 3
    rst = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk_in);
        if (AN != '1) got = 1'b1;
      end
      chk("first_lit_AN", 32'(AN), 32'hE);
      chk("first_lit_LEDout", 32'(LEDout), 32'h19);
    end
    sync_frame();
    sample_frame(-1, '0);
    chk("scan_seg0", 32'(segv[0]), 32'h19);
    chk("scan_seg1", 32'(segv[1]), 32'h30);
    chk("scan_seg2", 32'(segv[2]), 32'h24);
    chk("scan_seg3", 32'(segv[3]), 32'h79);
    for (int d = 0; d < ND; d++) chk($sformatf("scan_low_cnt%0d", d), 32'(lowc[d]), 32'd6);
    chk("frame_tick_period", 32'(ftpos), 32'(FRAME - 1));
    chk("scan_off_clean", 32'(offbad), 32'd0);

    // brightness 1 then 0
    brightness = 2'd1;
    sync_frame();
    sample_frame(-1, '0);
    for (int d = 0; d < ND; d++) chk($sformatf("bright1_low_cnt%0d", d), 32'(lowc[d]), 32'd2);
    brightness = 2'd0;
    sync_frame();
    sample_frame(-1, '0);
    chk("bright0_any_low", 32'(lowc[0] + lowc[1] + lowc[2] + lowc[3]), 32'd0);
    chk("bright0_off_clean", 32'(offbad), 32'd0);

    // leading-zero suppression
    brightness = 2'd3; lz_blank = 1'b1; digits_in = 16'h0050;
    sync_frame();
    sample_frame(-1, '0);
    chk("lz_d3_dark", 32'(lowc[3]), 32'd0);
    chk("lz_d2_dark", 32'(lowc[2]), 32'd0);
    chk("lz_d1_seg", 32'(segv[1]), 32'h12);
    chk("lz_d0_seg", 32'(segv[0]), 32'h40);
    digits_in = 16'h0000;
    sync_frame();
    sample_frame(-1, '0);
    chk("lz0_upper_dark", 32'(lowc[1] + lowc[2] + lowc[3]), 32'd0);
    chk("lz0_d0_lit", 32'(lowc[0]), 32'd6);
    chk("lz0_d0_seg", 32'(segv[0]), 32'h40);

    // tear-free capture: change during digit-1 slot
    lz_blank = 1'b0; digits_in = 16'h1234;
    sync_frame();
    sample_frame(12, 16'hABCD);
    chk("tear_seg0", 32'(segv[0]), 32'h19);
    chk("tear_seg1", 32'(segv[1]), 32'h30);
    chk("tear_seg2", 32'(segv[2]), 32'h24);
    chk("tear_seg3", 32'(segv[3]), 32'h79);
    sample_frame(-1, '0);
    chk("next_seg0", 32'(segv[0]), 32'h21);
    chk("next_seg1", 32'(segv[1]), 32'h46);
    chk("next_seg2", 32'(segv[2]), 32'h03);
    chk("next_seg3", 32'(segv[3]), 32'h08);

    // decimal point and blanking
    digits_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b0100;
    sync_frame();
    sample_frame(-1, '0);
    chk("dp_on_d1", 32'(dpl[1] > 0), 32'd1);
    chk("dp_off_others", 32'(dpl[0] + dpl[2] + dpl[3]), 32'd0);
    chk("blank_d2", 32'(lowc[2]), 32'd0);

    // asynchronous reset between edges
    dp_in = '0; blank_in = '0;
    repeat (5) @(negedge clk_in);
    @(posedge clk_in);
    #1 rst = 1'b0;
    #1;
    chk("async_AN", 32'(AN), 32'hF);
    chk("async_LEDout", 32'(LEDout), 32'h7F);
    chk("async_DP", 32'(DP), 32'd1);
    @(negedge clk_in);
    rst = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk_in);
        if (AN != '1) got = 1'b1;
      end
      chk("restart_AN", 32'(AN), 32'hE);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 19) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        dp_in = 4'($urandom); blank_in = 4'($urandom); lz_blank = 1'($urandom);
      end
      if ($urandom_range(0, 29) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 19) == 0) digits_in = {8'h00, 8'($urandom)};
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk_in);
        rst = 1'b1;
      end
    end

    repeat (2) @(negedge clk_in);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
